text_scroller: RTL and testbench

TEXT_SCROLLER -- requirements
Module: text_scroller

---
 rtl/text_scroller.sv | 140 ++++++++++++++
 tb/tb_text_scroller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/text_scroller.sv
// rtl/text_scroller.sv - scrolling character window over a writable message buffer
//
// Purpose: holds a message of up to MAX_LEN character codes and presents a
// DIGITS-wide sliding window over it, advancing one position per slide tick,
// wrapping cyclically and pausing PAUSE_TICKS ticks at the message start.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   tick_slide one-cycle slide strobe
//   en         scroll enable
//   wr_en      buffer write strobe
//   wr_addr    buffer write index
//   wr_data    character code to write
//   msg_len    active message length (0 treated as 1, clamped to MAX_LEN)
//   win        registered window, digit 0 in the MSB slice
//   pos        current window start index
//   wrap       one-cycle pulse when pos returns to 0
//   paused     high while holding at the message start
module text_scroller #(
  parameter int DIGITS      = 4,
  parameter int MAX_LEN     = 16,
  parameter int CW          = 5,
  parameter int PAUSE_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_slide,
  input  logic                         en,
  input  logic                         wr_en,
  input  logic [$clog2(MAX_LEN)-1:0]   wr_addr,
  input  logic [CW-1:0]                wr_data,
  input  logic [$clog2(MAX_LEN):0]     msg_len,
  output logic [DIGITS*CW-1:0]         win,
  output logic [$clog2(MAX_LEN)-1:0]   pos,
  output logic                         wrap,
  output logic                         paused
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(PAUSE_TICKS + 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCROLL = 2'd1;
  localparam logic [1:0] S_PAUSE  = 2'd2;

  logic [1:0]           state;
  logic [PW-1:0]        pause_cnt;
  logic [CW-1:0]        mem [0:MAX_LEN-1];
  logic [LW-1:0]        eff_len;
  logic [LW-1:0]        pos_inc;
  logic [DIGITS*CW-1:0] win_next;
  logic [LW-1:0]        r;
  logic [LW-1:0]        nxt;
  logic [AW-1:0]        idx;

  assign paused  = (state == S_PAUSE);
  assign pos_inc = {1'b0, pos} + LW'(1);

  always_comb begin
    if (msg_len == '0)
      eff_len = LW'(1);
    else if (msg_len > LW'(MAX_LEN))
      eff_len = LW'(MAX_LEN);
    else
      eff_len = msg_len;
  end

  // pos may exceed L after the length shrinks, so reduce it with repeated
  // conditional subtraction; later digits just step and wrap at L.
  always_comb begin
    r = {1'b0, pos};
    for (int i = 0; i < MAX_LEN; i++)
      if (r >= eff_len) r = r - eff_len;
    idx      = r[AW-1:0];
    nxt      = '0;
    win_next = '0;
    for (int k = 0; k < DIGITS; k++) begin
      win_next[(DIGITS-1-k)*CW +: CW] = mem[idx];
      nxt = {1'b0, idx} + LW'(1);
      idx = (nxt < eff_len) ? nxt[AW-1:0] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '1;
      win <= '1;
    end else begin
      if (wr_en && ({1'b0, wr_addr} < LW'(MAX_LEN)))
        mem[wr_addr] <= wr_data;
      win <= win_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pos       <= '0;
      pause_cnt <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (!en) begin
        state     <= S_IDLE;
        pause_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: state <= S_SCROLL;
          S_SCROLL: begin
            if (tick_slide) begin
              // pos_inc >= L also covers pos stranded beyond a shrunk length
              if (pos_inc < eff_len) begin
                pos <= pos_inc[AW-1:0];
              end else begin
                pos       <= '0;
                wrap      <= 1'b1;
                pause_cnt <= PW'(PAUSE_TICKS);
                state     <= (PAUSE_TICKS != 0) ? S_PAUSE : S_SCROLL;
              end
            end
          end
          S_PAUSE: begin
            if (tick_slide) begin
              if (pause_cnt <= PW'(1)) begin
                pause_cnt <= '0;
                state     <= S_SCROLL;
              end else begin
                pause_cnt <= pause_cnt - PW'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_scroller.sv
// tb/tb_text_scroller.sv - self-checking bench for text_scroller
module tb_text_scroller;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_slide;
  logic        en;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [4:0]  msg_len;
  logic [19:0] win;
  logic [3:0]  pos;
  logic        wrap;
  logic        paused;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q [$];
  logic [19:0] exp_w;

  localparam logic [4:0] CH_A = 5'd10;
  localparam logic [4:0] CH_B = 5'd11;
  localparam logic [4:0] BL   = 5'd31;

  text_scroller dut (
    .clk(clk), .rst(rst), .tick_slide(tick_slide), .en(en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .msg_len(msg_len),
    .win(win), .pos(pos), .wrap(wrap), .paused(paused)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] w4(input logic [4:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_slide = 0; en = 0; wr_en = 0; wr_addr = 0; wr_data = 0; msg_len = 5'd8;
    step(); step();
    checks++; if (pos !== 4'd0) begin errors++; $display("FAIL reset_pos got %0d exp 0", pos); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", wrap); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got %b exp 0", paused); end
    checks++; if (win !== 20'hFFFFF) begin errors++; $display("FAIL reset_win got %h exp fffff", win); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_scroll();
    for (int i = 0; i < 8; i++) wr(4'(i), 5'(i));
    en = 1'b1; tick_slide = 1'b1;
    step();
    checks++; if (pos !== 4'd0) begin errors++; $display("FAIL start_tick_ignored got %0d exp 0", pos); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pos !== 4'(i)) begin errors++; $display("FAIL scroll_pos got %0d exp %0d", pos, i); end
    end
    tick_slide = 1'b0;
    exp_q.push_back(w4(5'd3, 5'd4, 5'd5, 5'd6));
    step();
    exp_w = exp_q.pop_front();
    checks++; if (win !== exp_w) begin errors++; $display("FAIL scroll_win got %h exp %h", win, exp_w); end
  endtask

  task automatic test_wrap();
    tick_slide = 1'b1;
    repeat (4) step();
    checks++; if (pos !== 4'd7) begin errors++; $display("FAIL wrap_pre_pos got %0d exp 7", pos); end
    step();
    checks++; if (pos !== 4'd0) begin errors++; $display("FAIL wrap_pos got %0d exp 0", pos); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b exp 1", wrap); end
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL wrap_paused got %b exp 1", paused); end
    tick_slide = 1'b0;
    step();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle got %b exp 0", wrap); end
    tick_slide = 1'b1;
    step();
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_hold got %b exp 1", paused); end
    step();
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_end got %b exp 0", paused); end
    checks++; if (pos !== 4'd0) begin errors++; $display("FAIL pause_pos got %0d exp 0", pos); end
    step();
    checks++; if (pos !== 4'd1) begin errors++; $display("FAIL post_pause_pos got %0d exp 1", pos); end
    tick_slide = 1'b0;
  endtask

  task automatic test_short_len();
    en = 1'b0;
    step();
    wr(4'd0, CH_A);
    wr(4'd1, CH_B);
    msg_len = 5'd2; en = 1'b1;
    step();
    tick_slide = 1'b1;
    step();
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL short_wrap got %b exp 1", wrap); end
    tick_slide = 1'b0; en = 1'b0;
    exp_q.push_back(w4(CH_A, CH_B, CH_A, CH_B));
    step();
    exp_w = exp_q.pop_front();
    checks++; if (win !== exp_w) begin errors++; $display("FAIL len2_win got %h exp %h", win, exp_w); end
    msg_len = 5'd0;
    exp_q.push_back(w4(CH_A, CH_A, CH_A, CH_A));
    step();
    exp_w = exp_q.pop_front();
    checks++; if (win !== exp_w) begin errors++; $display("FAIL len0_win got %h exp %h", win, exp_w); end
    msg_len = 5'd20;
    exp_q.push_back(w4(CH_A, CH_B, 5'd2, 5'd3));
    step();
    exp_w = exp_q.pop_front();
    checks++; if (win !== exp_w) begin errors++; $display("FAIL len20_win got %h exp %h", win, exp_w); end
  endtask

  task automatic test_enable_hold();
    wr(4'd0, 5'd0);
    wr(4'd1, 5'd1);
    msg_len = 5'd8; en = 1'b1;
    step();
    tick_slide = 1'b1;
    repeat (5) step();
    checks++; if (pos !== 4'd5) begin errors++; $display("FAIL en_pre_pos got %0d exp 5", pos); end
    en = 1'b0; tick_slide = 1'b0;
    step();
    tick_slide = 1'b1;
    repeat (3) step();
    checks++; if (pos !== 4'd5) begin errors++; $display("FAIL idle_hold_pos got %0d exp 5", pos); end
    en = 1'b1;
    step();
    checks++; if (pos !== 4'd5) begin errors++; $display("FAIL resume_ignored got %0d exp 5", pos); end
    step();
    checks++; if (pos !== 4'd6) begin errors++; $display("FAIL resume_pos got %0d exp 6", pos); end
    tick_slide = 1'b0;
  endtask

  task automatic test_shrink();
    msg_len = 5'd4;
    exp_q.push_back(w4(5'd2, 5'd3, 5'd0, 5'd1));
    step();
    exp_w = exp_q.pop_front();
    checks++; if (win !== exp_w) begin errors++; $display("FAIL shrink_win got %h exp %h", win, exp_w); end
    checks++; if (pos !== 4'd6) begin errors++; $display("FAIL shrink_pos_hold got %0d exp 6", pos); end
    tick_slide = 1'b1;
    step();
    tick_slide = 1'b0;
    checks++; if (pos !== 4'd0) begin errors++; $display("FAIL shrink_wrap_pos got %0d exp 0", pos); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL shrink_wrap got %b exp 1", wrap); end
  endtask

  task automatic test_async_reset_and_write();
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pre_reset_paused got %b exp 1", paused); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pos !== 4'd0) begin errors++; $display("FAIL areset_pos got %0d exp 0", pos); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL areset_wrap got %b exp 0", wrap); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL areset_paused got %b exp 0", paused); end
    checks++; if (win !== 20'hFFFFF) begin errors++; $display("FAIL areset_win got %h exp fffff", win); end
    step();
    rst = 1'b0;
    msg_len = 5'd8; en = 1'b1;
    step();
    checks++; if (wrap !== 1'b0 || paused !== 1'b0) begin errors++; $display("FAIL post_reset_flags got %b%b exp 00", wrap, paused); end
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 5'd9; tick_slide = 1'b1;
    step();
    wr_en = 1'b0; tick_slide = 1'b0;
    checks++; if (pos !== 4'd1) begin errors++; $display("FAIL wr_tick_pos got %0d exp 1", pos); end
    exp_q.push_back(w4(BL, 5'd9, BL, BL));
    step();
    exp_w = exp_q.pop_front();
    checks++; if (win !== exp_w) begin errors++; $display("FAIL wr_tick_win got %h exp %h", win, exp_w); end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_wrap();
    test_short_len();
    test_enable_hold();
    test_shrink();
    test_async_reset_and_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
